conv_window_sequencer: RTL and testbench
========================================

// Module: conv_window_sequencer
// PURPOSE
//  Controller that feeds the 3x3 Gaussian kernel engine from a raster pixel stream.
//  Buffers two image lines plus a 3x3 window and serialises each complete window into
//  the engine as 9 bytes, one per cycle. Waits for the engine result and hands it
//  downstream, e.g. to the UART transmitter. Sits between the UART RX byte stream and
//  the kernel engine; only interior pixels produce output ((IMG_W-2)*(IMG_H-2) per frame).
// PARAMETERS
//  IMG_W  32  pixels per line, >=3; x counter width = clog2(IMG_W)
//  IMG_H  32  lines per frame, >=3; y counter width = clog2(IMG_H)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  pix_valid    in   1  input pixel present
//  pix_data     in   8  input pixel, raster order, row 0 first
//  pix_ready    out  1  block accepts pixel; transfer on edge with pix_valid&pix_ready
//  kern_en      out  1  engine sample strobe (to sin_en)
//  kern_data    out  8  engine sample (to in_data)
//  kern_done    in   1  engine result-valid level (from sys_enable)
//  kern_result  in   8  engine result (from cbit_out)
//  out_valid    out  1  result available; held until out_ready
//  out_data     out  8  filtered pixel, stable while out_valid
//  out_ready    in   1  downstream accepts; transfer on edge with out_valid&out_ready
//  frame_done   out  1  one-cycle pulse after last output of a frame is transferred
//  err          out  1  sticky; engine failed to complete on time; cleared only by reset
// BEHAVIOUR
//  Reset values: pix_ready=0, kern_en=0, kern_data=0, out_valid=0, out_data=0,
//   frame_done=0, err=0, x=y=0, window=0, state=SYNC. Line RAM contents are not reset.
//  Engine contract: engine has no reset and consumes one sample per cycle while kern_en=1.
//   It sets kern_done=1 on the edge taking sample 9 and clears it on the edge taking the
//   next sample 1. kern_done=1 therefore implies the engine is at window start.
//  SYNC: kern_en = ~kern_done (combinational), kern_data=0. Exit to ACCEPT on first
//   cycle kern_done=1. Takes at most 9 cycles. Also entered on reset release and on err.
//  ACCEPT: pix_ready=1. On accept at (x,y): write line RAMs, shift window one column
//   (rows y-2,y-1,y). Advance x; wrap x at IMG_W-1 and increment y.
//   If x>=2 and y>=2, go to FEED; otherwise stay in ACCEPT.
//  FEED: pix_ready=0, kern_en=1 for exactly 9 consecutive cycles. kern_data order is
//   row-major, top-left first: w00,w01,w02,w10..w22. Then go to WAIT.
//  WAIT: kern_en=0. If kern_done=1, register kern_result into out_data, set out_valid,
//   and go to OUT. If kern_done=0, set err and go to SYNC.
//  OUT: hold out_valid/out_data until out_ready=1. Transfer edge returns to ACCEPT.
//   If the transferred pixel is the frame's last pixel, frame_done pulses in the next
//   cycle and x,y are already 0. pix_ready stays 0 in OUT; there is no same-cycle accept.
//  Latency: accept at edge A -> samples on edges A+1..A+9 -> out_valid from edge A+10.
//  Last pixel of frame (IMG_W-1,IMG_H-1): x,y wrap to 0 on accept. Next frame starts
//   clean and needs no SYNC.
//  Edge columns/rows (x<2 or y<2): buffered only, no FEED, no output.
//  rst_n low mid-FEED/WAIT/OUT: all outputs go to reset values immediately, any pending
//   output is dropped, and SYNC realigns the engine after release.
//  No arithmetic in this block: the result is forwarded unchanged.
//   Engine result = (sum w*p)>>4 with weights 1 2 1 / 2 4 2 / 1 2 1.
// TESTING
//  1 Engine model left at sample index 3, kern_done=0, release rst_n -> kern_en high
//    exactly 6 cycles, then pix_ready=1.
//  2 IMG_W=IMG_H=3, pixels 1..9 -> kern_data 1,2,..,9 on consecutive cycles,
//    out_data=5, frame_done one pulse.
//  3 IMG_W=IMG_H=4, all pixels 100 -> 4 outputs of 100, out_valid at A+10 each time,
//    frame_done once.
//  4 IMG_W=IMG_H=5, pixel(2,2)=160 else 0 -> 9 outputs: center 40, edge-adjacent 20,
//    corners 10.
//  5 out_ready low 20 cycles -> out_valid=1, out_data stable, pix_ready=0;
//    raise out_ready -> single transfer.
//  6 rst_n low after 4 FEED samples -> outputs reset at once; after release SYNC drives
//    5 samples. Separately: engine model holding kern_done=0 in WAIT -> err=1 and SYNC.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// Feeds a 3x3 kernel engine from a raster pixel stream: two line buffers plus a 3x3 window,
// each interior window serialised as 9 samples, engine result handed downstream.
module conv_window_sequencer #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       kern_en,
    output logic [7:0] kern_data,
    input  logic       kern_done,
    input  logic [7:0] kern_result,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       err
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {SYNC, ACCEPT, FEED, WAIT, OUT} state_t;

    state_t        state, next_state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    cnt;
    logic [7:0]    line0 [IMG_W];
    logic [7:0]    line1 [IMG_W];
    logic [7:0]    win   [9];
    logic          accept;
    logic          interior;

    assign accept   = (state == ACCEPT) && pix_valid;
    assign interior = (x >= XW'(2)) && (y >= YW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            SYNC:    if (kern_done) next_state = ACCEPT;
            ACCEPT:  if (pix_valid && interior) next_state = FEED;
            FEED:    if (cnt == 4'd8) next_state = WAIT;
            WAIT:    next_state = kern_done ? OUT : SYNC;
            OUT:     if (out_ready) next_state = ACCEPT;
            default: next_state = SYNC;
        endcase
    end

    // SYNC clocks the engine until it reports window start; gated so reset forces kern_en low
    always_comb begin
        pix_ready = 1'b0;
        kern_en   = 1'b0;
        kern_data = 8'd0;
        unique case (state)
            SYNC:    kern_en = rst_n & ~kern_done;
            ACCEPT:  pix_ready = 1'b1;
            FEED: begin
                kern_en   = 1'b1;
                kern_data = win[cnt];
            end
            default: ;
        endcase
    end

    // Line RAMs hold rows y-2 (line0) and y-1 (line1) for every column
    always_ff @(posedge clk) begin
        if (accept) begin
            line0[x] <= line1[x];
            line1[x] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            cnt        <= 4'd0;
            out_valid  <= 1'b0;
            out_data   <= 8'd0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 9; i++) win[i] <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r*3]     <= win[r*3 + 1];
                    win[r*3 + 1] <= win[r*3 + 2];
                end
                win[2] <= line0[x];
                win[5] <= line1[x];
                win[8] <= pix_data;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
            cnt <= (state == FEED && cnt != 4'd8) ? cnt + 4'd1 : 4'd0;
            if (state == WAIT) begin
                if (kern_done) begin
                    out_valid <= 1'b1;
                    out_data  <= kern_result;
                end else begin
                    err <= 1'b1;
                end
            end
            // x,y have already wrapped when the frame's last result leaves
            if (state == OUT && out_ready) begin
                out_valid  <= 1'b0;
                frame_done <= (x == '0) && (y == '0);
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer on a 5x5 image with a behavioural Gaussian engine.
module tb_conv_window_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       kern_en;
    logic [7:0] kern_data;
    logic       kern_done;
    logic [7:0] kern_result;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       frame_done;
    logic       err;

    conv_window_sequencer #(.IMG_W(5), .IMG_H(5)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .kern_en(kern_en), .kern_data(kern_data),
        .kern_done(kern_done), .kern_result(kern_result), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .frame_done(frame_done), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int exp_fd = 0;
    int img [5][5];
    int w3 [3] = '{1, 2, 1};
    int exp_q [$];
    int lat_q [$];
    int samp_q [$];
    bit stall_req = 0;
    bit hold_low = 0;

    int         eidx = 3;
    int         eacc = 0;
    logic       edone = 1'b0;
    logic [7:0] eres = 8'd0;

    assign kern_done   = edone;
    assign kern_result = eres;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: no reset, one sample per kern_en cycle, done set on sample 9
    always @(posedge clk) begin
        if (kern_en) begin
            if (eidx == 0) edone <= 1'b0;
            if (eidx == 8) begin
                eres  <= 8'((eacc + w3[2] * w3[2] * int'(kern_data)) >> 4);
                edone <= !hold_low;
                eidx  <= 0;
                eacc  <= 0;
            end else begin
                eacc <= eacc + w3[eidx / 3] * w3[eidx % 3] * int'(kern_data);
                eidx <= eidx + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gauss(input int cx, input int cy);
        int s = 0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                s += w3[dy] * w3[dx] * img[cy - 1 + dy][cx - 1 + dx];
        return s >> 4;
    endfunction

    always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

    always @(negedge clk) begin
        if (rst_n && kern_en && samp_q.size() > 0) checkOutput("kern_data", kern_data, samp_q.pop_front());
    end

    // Output monitor: latency on rising out_valid, optional 20-cycle stall, then pop and compare
    initial begin
        bit   prev_valid = 0;
        bit   ok;
        logic [7:0] held;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (!prev_valid) begin
                    if (lat_q.size() > 0) checkOutput("latency", cyc - lat_q.pop_front(), 10);
                    else checkOutput("unexpected_out_valid", 1, 0);
                end
                if (stall_req) begin
                    stall_req = 0;
                    out_ready = 1'b0;
                    held = out_data;
                    ok = 1;
                    repeat (20) begin
                        @(negedge clk);
                        if (!out_valid || out_data !== held || pix_ready) ok = 0;
                    end
                    checkOutput("stall_hold", ok, 1);
                    out_ready = 1'b1;
                end
                if (exp_q.size() > 0) checkOutput("out_data", out_data, exp_q.pop_front());
                else checkOutput("extra_output", 1, 0);
            end
            prev_valid = rst_n && out_valid;
        end
    end

    task automatic applyStimulus(input int px, input int py, input bit expect_out);
        int t = 0;
        int ca;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = 8'(img[py][px]);
        while (!pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checkOutput("accept_timeout", 1, 0);
            pix_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        ca = cyc;
        if (px >= 2 && py >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    samp_q.push_back(img[py - 2 + r][px - 2 + c]);
            if (expect_out) begin
                exp_q.push_back(gauss(px - 1, py - 1));
                lat_q.push_back(ca);
            end
        end
    endtask

    task automatic sendFrame();
        for (int yy = 0; yy < 5; yy++)
            for (int xx = 0; xx < 5; xx++)
                applyStimulus(xx, yy, 1);
    endtask

    task automatic waitDrain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) checkOutput("drain_timeout", 1, 0);
        repeat (3) @(negedge clk);
        exp_fd++;
        checkOutput("frame_done_count", fd_cnt, exp_fd);
    endtask

    // Called at a negedge; counts engine-clocking cycles until the block starts accepting
    task automatic syncCount(input int expected);
        int n = 0;
        int t = 0;
        while (!pix_ready && t < 100) begin
            if (kern_en) n++;
            @(negedge clk);
            t++;
        end
        checkOutput("sync_len", n, expected);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_pix_ready", pix_ready, 0);
        checkOutput("rst_kern_en", kern_en, 0);
        checkOutput("rst_kern_data", kern_data, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_err", err, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        syncCount(6);

        $display("[TB] impulse frame");
        foreach (img[i, j]) img[i][j] = 0;
        img[2][2] = 160;
        stall_req = 1;
        sendFrame();
        waitDrain();

        $display("[TB] flat frame");
        foreach (img[i, j]) img[i][j] = 100;
        sendFrame();
        waitDrain();

        $display("[TB] ramp frame");
        foreach (img[i, j]) img[i][j] = i * 5 + j + 1;
        sendFrame();
        waitDrain();

        $display("[TB] reset during FEED");
        foreach (img[i, j]) img[i][j] = (i * 37 + j * 11) % 256;
        for (int k = 0; k <= 12; k++) applyStimulus(k % 5, k / 5, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkResetOutputs();
        samp_q.delete();
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        syncCount(5);
        sendFrame();
        waitDrain();

        $display("[TB] engine timeout");
        foreach (img[i, j]) img[i][j] = 50 + i + j;
        for (int k = 0; k < 12; k++) applyStimulus(k % 5, k / 5, 0);
        hold_low = 1;
        applyStimulus(2, 2, 0);
        t = 0;
        while (!err && t < 40) begin
            @(negedge clk);
            t++;
        end
        hold_low = 0;
        checkOutput("err_set", err, 1);
        syncCount(9);
        checkOutput("err_sticky", err, 1);
        checkOutput("err_no_output", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
